// File: rtl/rom_stream_ctrl.sv
// ROM sequencer: issues a run of wrapping ROM addresses and streams the
// returned samples downstream through a 2-entry registered output buffer.
module rom_stream_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int ROM_DEPTH       = 512,
    parameter int ADDR_WIDTH_BITS = $clog2(ROM_DEPTH)
) (
    input  logic                         sys_clock,
    input  logic                         sys_reset,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [ADDR_WIDTH_BITS-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH_BITS:0]     length_i,
    output logic [ADDR_WIDTH_BITS-1:0]   rom_addr_o,
    input  logic signed [DATA_WIDTH-1:0] rom_data_i,
    output logic signed [DATA_WIDTH-1:0] m_data_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic                         m_last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int AW = ADDR_WIDTH_BITS;
    localparam int CW = ADDR_WIDTH_BITS + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(ROM_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_len;
    logic [CW-1:0] r_iss;
    logic [CW-1:0] r_acc;
    logic [AW-1:0] r_addr;
    logic          r_inflight;
    logic          r_if_last;

    logic signed [DATA_WIDTH-1:0] r_hd_d;
    logic signed [DATA_WIDTH-1:0] r_tl_d;
    logic                         r_hd_v;
    logic                         r_hd_l;
    logic                         r_tl_v;
    logic                         r_tl_l;

    logic signed [DATA_WIDTH-1:0] w_hd_d;
    logic signed [DATA_WIDTH-1:0] w_tl_d;
    logic                         w_hd_v;
    logic                         w_hd_l;
    logic                         w_tl_v;
    logic                         w_tl_l;

    logic          w_start;
    logic          w_abort;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [2:0]    w_occ;
    logic [CW-1:0] w_len_cl;
    logic [CW-1:0] w_iss_nxt;
    logic [CW-1:0] w_acc_nxt;

    assign w_start  = (r_state == IDLE) && start_i;
    assign w_abort  = abort_i && ((r_state == RUN) || (r_state == DRAIN));
    assign w_pop    = r_hd_v && m_ready_i;
    assign w_push   = r_inflight;
    assign w_len_cl = (length_i > DEPTH_C) ? DEPTH_C : length_i;

    // Occupancy counts the read in flight so the buffer can never overflow.
    assign w_occ = 3'(r_hd_v) + 3'(r_tl_v) + 3'(r_inflight);

    assign w_issue = (r_state == RUN) && !abort_i
                  && (r_iss < r_len)
                  && (w_occ < (3'd2 + 3'(w_pop)));

    assign w_iss_nxt = r_iss + CW'(w_issue);
    assign w_acc_nxt = r_acc + CW'(w_pop);

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = (w_len_cl == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (w_iss_nxt == r_len) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    w_state_nxt = IDLE;
                end else if (w_acc_nxt == r_len) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            r_len      <= '0;
            r_iss      <= '0;
            r_acc      <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_if_last  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_if_last  <= w_issue && (r_iss == (r_len - CW'(1)));
            if (w_start) begin
                r_len  <= w_len_cl;
                r_iss  <= '0;
                r_acc  <= '0;
                r_addr <= base_addr_i;
            end else begin
                r_iss <= w_iss_nxt;
                r_acc <= w_acc_nxt;
                if (w_issue) begin
                    r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
                end
            end
        end
    end

    // Head register drives the outputs directly; tail absorbs a stall.
    always_comb begin
        w_hd_d = r_hd_d;
        w_hd_v = r_hd_v;
        w_hd_l = r_hd_l;
        w_tl_d = r_tl_d;
        w_tl_v = r_tl_v;
        w_tl_l = r_tl_l;
        if (w_pop) begin
            w_hd_d = r_tl_d;
            w_hd_l = r_tl_l;
            w_hd_v = r_tl_v;
            w_tl_v = 1'b0;
        end
        if (w_push) begin
            if (!w_hd_v) begin
                w_hd_d = rom_data_i;
                w_hd_l = r_if_last;
                w_hd_v = 1'b1;
            end else begin
                w_tl_d = rom_data_i;
                w_tl_l = r_if_last;
                w_tl_v = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            r_hd_d <= '0;
            r_hd_v <= 1'b0;
            r_hd_l <= 1'b0;
            r_tl_d <= '0;
            r_tl_v <= 1'b0;
            r_tl_l <= 1'b0;
        end else if (w_abort) begin
            r_hd_v <= 1'b0;
            r_hd_l <= 1'b0;
            r_tl_v <= 1'b0;
            r_tl_l <= 1'b0;
        end else begin
            r_hd_d <= w_hd_d;
            r_hd_v <= w_hd_v;
            r_hd_l <= w_hd_l;
            r_tl_d <= w_tl_d;
            r_tl_v <= w_tl_v;
            r_tl_l <= w_tl_l;
        end
    end

    assign rom_addr_o = r_addr;
    assign m_data_o   = r_hd_d;
    assign m_valid_o  = r_hd_v;
    assign m_last_o   = r_hd_v && r_hd_l;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = (r_state == DONE);

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Bench for rom_stream_ctrl: random ROM image, registered ROM model and
// an address-order expectation computed from base/length modulo depth.
module tb_rom_stream_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [AW-1:0]        base_addr;
    logic [AW:0]          length;
    logic [AW-1:0]        rom_addr;
    logic signed [DW-1:0] rom_data;
    logic signed [DW-1:0] m_data;
    logic                 m_valid;
    logic                 ready;
    logic                 m_last;
    logic                 busy;
    logic                 done;

    logic [DW-1:0] mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    rom_stream_ctrl #(
        .DATA_WIDTH(DW),
        .ROM_DEPTH(DEPTH),
        .ADDR_WIDTH_BITS(AW)
    ) dut (
        .sys_clock(clk),
        .sys_reset(rst),
        .start_i(start),
        .abort_i(abort),
        .base_addr_i(base_addr),
        .length_i(length),
        .rom_addr_o(rom_addr),
        .rom_data_i(rom_data),
        .m_data_o(m_data),
        .m_valid_o(m_valid),
        .m_ready_i(ready),
        .m_last_o(m_last),
        .busy_o(busy),
        .done_o(done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, 32'(rom_addr), 0);
        check({tag, "_valid"}, 32'(m_valid), 0);
        check({tag, "_last"}, 32'(m_last), 0);
        check({tag, "_data"}, m_data, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    // stall_pct < 0 selects the fixed 1,0,0 ready pattern.
    task automatic do_run(input int base, input int len, input int stall_pct,
                          input bit timed, input int glitch_t);
        int exp_n, beats, dones, done_t, first_v, last_t;
        bit prev_stall;
        logic [DW-1:0] prev_d;
        logic prev_l;
        exp_n = (len > DEPTH) ? DEPTH : len;
        beats = 0; dones = 0; done_t = -1; first_v = -1; last_t = -1;
        prev_stall = 0; prev_d = '0; prev_l = 0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            start     = (t == 0) || (t == glitch_t);
            base_addr = (t == 0) ? AW'(base) : AW'(base + 7);
            length    = (t == 0) ? (AW+1)'(len) : (AW+1)'(3);
            if (stall_pct < 0) ready = (t % 3 == 0);
            else ready = ($urandom_range(99) >= stall_pct);
            if (timed && t >= 1 && t <= exp_n)
                check("addr", 32'(rom_addr), 32'((base + t - 1) % DEPTH));
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_data", m_data, prev_d);
                check("hold_last", 32'(m_last), 32'(prev_l));
            end
            if (m_valid && first_v < 0) first_v = t;
            if (done) begin
                dones++;
                done_t = t;
            end
            if (m_valid && ready) begin
                if (beats < exp_n) begin
                    check("data", m_data, mem[(base + beats) % DEPTH]);
                    check("last", 32'(m_last), 32'(beats == exp_n - 1));
                end else begin
                    check("extra_beat", beats + 1, exp_n);
                end
                if (m_last) last_t = t;
                beats++;
            end
            prev_stall = m_valid && !ready;
            prev_d = m_data;
            prev_l = m_last;
            if (timed && done_t >= 0 && t == done_t + 1)
                check("busy_fall", 32'(busy), 0);
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        start = 0;
        if (done_t < 0) check("done_timeout", 0, 1);
        check("beats", beats, exp_n);
        check("done_count", dones, 1);
        check("busy_end", 32'(busy), 0);
        if (exp_n == 0) check("len0_done_soon", 32'(done_t >= 1 && done_t <= 2), 1);
        if (timed) begin
            check("first_valid_t", first_v, 3);
            check("last_t", last_t, exp_n + 2);
            check("done_t", done_t, exp_n + 3);
        end
    endtask

    task automatic do_abort(input int base, input int len, input int after);
        int beats, dones;
        beats = 0; dones = 0;
        @(negedge clk);
        start = 1; base_addr = AW'(base); length = (AW+1)'(len);
        ready = 1; abort = 0;
        for (int t = 0; t < 200 && beats < after; t++) begin
            if (t > 0) begin
                @(negedge clk);
                start = 0;
            end
            if (m_valid && ready) begin
                check("ab_data", m_data, mem[(base + beats) % DEPTH]);
                beats++;
            end
        end
        check("ab_reached", beats, after);
        @(negedge clk);
        ready = 0; abort = 1;
        @(negedge clk);
        abort = 0;
        check("ab_valid", 32'(m_valid), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_done_now", 32'(done), 0);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("ab_no_done", dones, 0);
        check("ab_idle", 32'(busy), 0);
    endtask

    task automatic do_reset_mid();
        bit seen;
        seen = 0;
        @(negedge clk);
        start = 1; base_addr = AW'(200); length = (AW+1)'(16); ready = 1;
        for (int t = 1; t < 20; t++) begin
            @(negedge clk);
            start = (t == 1);
            if (m_valid) begin
                seen = 1;
                break;
            end
        end
        start = 0;
        check("rst_valid_seen", 32'(seen), 1);
        rst = 1;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        rst = 0;
        @(negedge clk);
        check("rst_stay_idle", 32'(busy), 0);
        check("rst_no_done", 32'(done), 0);
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; ready = 0;
        base_addr = '0; length = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 0;

        do_run(0, 8, 0, 1, -1);
        do_run(508, 6, 0, 1, -1);
        do_run(17, 8, -1, 0, -1);
        do_run($urandom_range(DEPTH - 1), 8, 40, 0, -1);
        do_run(5, 0, 0, 0, -1);
        do_run($urandom_range(DEPTH - 1), 600, 0, 0, -1);
        do_run(100, 12, 0, 1, 5);
        do_abort(40, 16, 5);
        do_run(3, 2, 0, 1, -1);
        do_reset_mid();
        do_run(250, 4, 0, 1, -1);
        for (int r = 0; r < 4; r++) begin
            do_run($urandom_range(DEPTH - 1), $urandom_range(40, 1),
                   $urandom_range(60), 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
